// File: rtl/branch_target_predictor.sv
// ============================================================================
// Module   : branch_target_predictor
// Brief    : Direct-mapped BTB with 2-bit saturating direction counters,
//            misprediction detection and saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_pc,
  input  logic             ex_valid,
  input  logic             ex_is_jump,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_pc,
  output logic             mispredict,
  output logic [31:0]      fix_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic             r_jump   [ENTRIES];

  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_miss_count;

  // Fetch-side lookup; reads registered state only, so a same-cycle update
  // to the same index is not yet visible here.
  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;

  assign w_if_idx   = if_pc[IDX_W+1:2];
  assign w_if_tag   = if_pc[31:IDX_W+2];
  assign w_if_hit   = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign pred_taken = w_if_hit && (r_jump[w_if_idx] || r_ctr[w_if_idx][1]);
  assign pred_pc    = pred_taken ? r_target[w_if_idx] : (if_pc + 32'd4);

  // Resolve-side lookup of the instruction retiring from EX.
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic [1:0]       w_ex_ctr;
  logic [1:0]       w_ctr_inc;
  logic [1:0]       w_ctr_dec;
  logic [1:0]       w_ctr_alloc;

  assign w_ex_idx    = ex_pc[IDX_W+1:2];
  assign w_ex_tag    = ex_pc[31:IDX_W+2];
  assign w_ex_hit    = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ex_ctr    = r_ctr[w_ex_idx];
  assign w_ctr_inc   = (w_ex_ctr == 2'b11) ? 2'b11 : (w_ex_ctr + 2'd1);
  assign w_ctr_dec   = (w_ex_ctr == 2'b00) ? 2'b00 : (w_ex_ctr - 2'd1);
  assign w_ctr_alloc = ex_is_jump ? 2'b11 : 2'b10;

  assign mispredict = ex_valid &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_pc)));
  assign fix_pc     = ex_taken ? ex_target : (ex_pc + 32'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
        r_jump[i]   <= 1'b0;
      end
    end else if (ex_valid) begin
      if (ex_taken) begin
        // Allocation on a miss overwrites whatever alias held the slot.
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= ex_target;
        r_jump[w_ex_idx]   <= ex_is_jump;
        r_ctr[w_ex_idx]    <= w_ex_hit ? w_ctr_inc : w_ctr_alloc;
      end else if (w_ex_hit) begin
        // Not-taken only weakens the counter; a jump flagged not-taken
        // (illegal) is handled the same way.
        r_ctr[w_ex_idx] <= w_ctr_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_count <= '0;
      r_miss_count   <= '0;
    end else if (ex_valid) begin
      if (r_branch_count != {CNT_W{1'b1}}) begin
        r_branch_count <= r_branch_count + CNT_W'(1);
      end
      if (mispredict && (r_miss_count != {CNT_W{1'b1}})) begin
        r_miss_count <= r_miss_count + CNT_W'(1);
      end
    end
  end

  assign branch_count = r_branch_count;
  assign miss_count   = r_miss_count;

endmodule

`default_nettype wire
